// File: rtl/fir_xifu_ex.sv
// fir_xifu_ex -- execute stage of the FIR XIFU coprocessor.
//
// Takes one instruction at a time from the ID/EX register and runs it:
//   XFIRDOTP  packed 2x16 dot product accumulated onto rd, written back next cycle
//   XFIRLW    word load through the XIF memory interface, written back to rd
//   XFIRSW    word store of rs2 through the XIF memory interface
//   INVALID   taken and dropped silently
// Misaligned loads/stores and memory errors drop the instruction and pulse err_o.
//
// Ports
//   clk_i, rst_i                  clock, synchronous active-high reset
//   id_*                          ID/EX register contents plus valid/ready handshake
//   rf_raddr_*_o / rf_rdata_*_i   three combinational regfile read ports (rs1, rs2, rd)
//   mem_*                         XIF memory request (valid/ready) and result channel
//   wb_*                          registered regfile write port (single-cycle valid)
//   err_o                         single-cycle pulse when an instruction is dropped
module fir_xifu_ex #(
    parameter int X_ID_WIDTH = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,

    input  logic                  id_valid_i,
    output logic                  id_ready_o,
    input  logic [1:0]            id_instr_i,
    input  logic [31:0]           id_base_i,
    input  logic [11:0]           id_offset_i,
    input  logic [4:0]            id_rs1_i,
    input  logic [4:0]            id_rs2_i,
    input  logic [4:0]            id_rd_i,
    input  logic [X_ID_WIDTH-1:0] id_xid_i,

    output logic [4:0]            rf_raddr_a_o,
    output logic [4:0]            rf_raddr_b_o,
    output logic [4:0]            rf_raddr_c_o,
    input  logic [31:0]           rf_rdata_a_i,
    input  logic [31:0]           rf_rdata_b_i,
    input  logic [31:0]           rf_rdata_c_i,

    output logic                  mem_valid_o,
    input  logic                  mem_ready_i,
    output logic [31:0]           mem_addr_o,
    output logic                  mem_we_o,
    output logic [3:0]            mem_be_o,
    output logic [31:0]           mem_wdata_o,
    output logic [X_ID_WIDTH-1:0] mem_xid_o,

    input  logic                  mem_result_valid_i,
    input  logic [31:0]           mem_result_rdata_i,
    input  logic                  mem_result_err_i,

    output logic                  wb_valid_o,
    output logic [4:0]            wb_rd_o,
    output logic [31:0]           wb_data_o,
    output logic [X_ID_WIDTH-1:0] wb_xid_o,

    output logic                  err_o
);

    localparam logic [1:0] INSTR_INVALID = 2'd0;
    localparam logic [1:0] INSTR_LW      = 2'd1;
    localparam logic [1:0] INSTR_SW      = 2'd2;
    localparam logic [1:0] INSTR_DOTP    = 2'd3;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MEM_REQ  = 2'd1,
        MEM_WAIT = 2'd2
    } state_e;

    state_e                  state_q,     state_d;
    logic                    mem_valid_q, mem_valid_d;
    logic [31:0]             mem_addr_q,  mem_addr_d;
    logic                    mem_we_q,    mem_we_d;
    logic [3:0]              mem_be_q,    mem_be_d;
    logic [31:0]             mem_wdata_q, mem_wdata_d;
    logic [X_ID_WIDTH-1:0]   xid_q,       xid_d;
    logic [4:0]              rd_q,        rd_d;
    logic                    wb_valid_q,  wb_valid_d;
    logic [4:0]              wb_rd_q,     wb_rd_d;
    logic [31:0]             wb_data_q,   wb_data_d;
    logic [X_ID_WIDTH-1:0]   wb_xid_q,    wb_xid_d;
    logic                    err_q,       err_d;

    logic        accept;
    logic [31:0] op_a, op_b, op_c;
    logic [31:0] addr;
    logic [31:0] prod_lo, prod_hi, dotp;

    assign rf_raddr_a_o = id_rs1_i;
    assign rf_raddr_b_o = id_rs2_i;
    assign rf_raddr_c_o = id_rd_i;

    assign id_ready_o = (state_q == IDLE);
    assign accept     = id_valid_i && id_ready_o;

    // The regfile write in flight this cycle is not visible on the read
    // ports yet, so a matching read takes the writeback value instead.
    assign op_a = (wb_valid_q && wb_rd_q == id_rs1_i) ? wb_data_q : rf_rdata_a_i;
    assign op_b = (wb_valid_q && wb_rd_q == id_rs2_i) ? wb_data_q : rf_rdata_b_i;
    assign op_c = (wb_valid_q && wb_rd_q == id_rd_i)  ? wb_data_q : rf_rdata_c_i;

    assign addr = id_base_i + {{20{id_offset_i[11]}}, id_offset_i};

    // Low 32 bits of the product of sign-extended halves equal the signed
    // product modulo 2^32, so unsigned multipliers are enough here.
    assign prod_lo = {{16{op_a[15]}}, op_a[15:0]}  * {{16{op_b[15]}}, op_b[15:0]};
    assign prod_hi = {{16{op_a[31]}}, op_a[31:16]} * {{16{op_b[31]}}, op_b[31:16]};
    assign dotp    = op_c + prod_lo + prod_hi;

    always_comb begin
        state_d     = state_q;
        mem_valid_d = mem_valid_q;
        mem_addr_d  = mem_addr_q;
        mem_we_d    = mem_we_q;
        mem_be_d    = mem_be_q;
        mem_wdata_d = mem_wdata_q;
        xid_d       = xid_q;
        rd_d        = rd_q;
        wb_valid_d  = 1'b0;
        wb_rd_d     = wb_rd_q;
        wb_data_d   = wb_data_q;
        wb_xid_d    = wb_xid_q;
        err_d       = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    unique case (id_instr_i)
                        INSTR_DOTP: begin
                            wb_valid_d = 1'b1;
                            wb_rd_d    = id_rd_i;
                            wb_data_d  = dotp;
                            wb_xid_d   = id_xid_i;
                        end
                        INSTR_LW, INSTR_SW: begin
                            if (addr[1:0] != 2'b00) begin
                                err_d = 1'b1;
                            end else begin
                                state_d     = MEM_REQ;
                                mem_valid_d = 1'b1;
                                mem_addr_d  = addr;
                                mem_we_d    = (id_instr_i == INSTR_SW);
                                mem_be_d    = 4'hF;
                                mem_wdata_d = op_b;
                                xid_d       = id_xid_i;
                                rd_d        = id_rd_i;
                            end
                        end
                        default: ;  // INVALID: consumed with no effect
                    endcase
                end
            end
            MEM_REQ: begin
                // Payload registers are untouched here, so they stay stable
                // for the whole stall.
                if (mem_ready_i) begin
                    state_d     = MEM_WAIT;
                    mem_valid_d = 1'b0;
                end
            end
            MEM_WAIT: begin
                if (mem_result_valid_i) begin
                    state_d = IDLE;
                    if (mem_result_err_i) begin
                        err_d = 1'b1;
                    end else if (!mem_we_q) begin
                        wb_valid_d = 1'b1;
                        wb_rd_d    = rd_q;
                        wb_data_d  = mem_result_rdata_i;
                        wb_xid_d   = xid_q;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            mem_valid_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_we_q    <= 1'b0;
            mem_be_q    <= '0;
            mem_wdata_q <= '0;
            xid_q       <= '0;
            rd_q        <= '0;
            wb_valid_q  <= 1'b0;
            wb_rd_q     <= '0;
            wb_data_q   <= '0;
            wb_xid_q    <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            mem_valid_q <= mem_valid_d;
            mem_addr_q  <= mem_addr_d;
            mem_we_q    <= mem_we_d;
            mem_be_q    <= mem_be_d;
            mem_wdata_q <= mem_wdata_d;
            xid_q       <= xid_d;
            rd_q        <= rd_d;
            wb_valid_q  <= wb_valid_d;
            wb_rd_q     <= wb_rd_d;
            wb_data_q   <= wb_data_d;
            wb_xid_q    <= wb_xid_d;
            err_q       <= err_d;
        end
    end

    assign mem_valid_o = mem_valid_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_we_o    = mem_we_q;
    assign mem_be_o    = mem_be_q;
    assign mem_wdata_o = mem_wdata_q;
    assign mem_xid_o   = xid_q;
    assign wb_valid_o  = wb_valid_q;
    assign wb_rd_o     = wb_rd_q;
    assign wb_data_o   = wb_data_q;
    assign wb_xid_o    = wb_xid_q;
    assign err_o       = err_q;

endmodule

// File: tb/tb_fir_xifu_ex.sv
// Directed bench for fir_xifu_ex. A static regfile model feeds the read
// ports and is never written, so forwarded values are distinguishable
// from stale regfile contents.
module tb_fir_xifu_ex;

    localparam int XW = 4;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          id_valid_i;
    logic          id_ready_o;
    logic [1:0]    id_instr_i;
    logic [31:0]   id_base_i;
    logic [11:0]   id_offset_i;
    logic [4:0]    id_rs1_i, id_rs2_i, id_rd_i;
    logic [XW-1:0] id_xid_i;
    logic [4:0]    rf_raddr_a_o, rf_raddr_b_o, rf_raddr_c_o;
    logic [31:0]   rf_rdata_a_i, rf_rdata_b_i, rf_rdata_c_i;
    logic          mem_valid_o, mem_ready_i;
    logic [31:0]   mem_addr_o;
    logic          mem_we_o;
    logic [3:0]    mem_be_o;
    logic [31:0]   mem_wdata_o;
    logic [XW-1:0] mem_xid_o;
    logic          mem_result_valid_i;
    logic [31:0]   mem_result_rdata_i;
    logic          mem_result_err_i;
    logic          wb_valid_o;
    logic [4:0]    wb_rd_o;
    logic [31:0]   wb_data_o;
    logic [XW-1:0] wb_xid_o;
    logic          err_o;

    logic [31:0] rf [32];
    int errors = 0;
    int checks = 0;

    assign rf_rdata_a_i = rf[rf_raddr_a_o];
    assign rf_rdata_b_i = rf[rf_raddr_b_o];
    assign rf_rdata_c_i = rf[rf_raddr_c_o];

    always #5 clk_i = ~clk_i;

    fir_xifu_ex #(.X_ID_WIDTH(XW)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .id_valid_i(id_valid_i), .id_ready_o(id_ready_o), .id_instr_i(id_instr_i),
        .id_base_i(id_base_i), .id_offset_i(id_offset_i),
        .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i), .id_rd_i(id_rd_i), .id_xid_i(id_xid_i),
        .rf_raddr_a_o(rf_raddr_a_o), .rf_raddr_b_o(rf_raddr_b_o), .rf_raddr_c_o(rf_raddr_c_o),
        .rf_rdata_a_i(rf_rdata_a_i), .rf_rdata_b_i(rf_rdata_b_i), .rf_rdata_c_i(rf_rdata_c_i),
        .mem_valid_o(mem_valid_o), .mem_ready_i(mem_ready_i), .mem_addr_o(mem_addr_o),
        .mem_we_o(mem_we_o), .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o), .mem_xid_o(mem_xid_o),
        .mem_result_valid_i(mem_result_valid_i), .mem_result_rdata_i(mem_result_rdata_i),
        .mem_result_err_i(mem_result_err_i),
        .wb_valid_o(wb_valid_o), .wb_rd_o(wb_rd_o), .wb_data_o(wb_data_o), .wb_xid_o(wb_xid_o),
        .err_o(err_o)
    );

    // Inputs change and outputs are sampled 1 ns after the rising edge.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [1:0] instr, input logic [31:0] base, input logic [11:0] off,
                         input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                         input logic [XW-1:0] xid);
        id_valid_i  = 1'b1;
        id_instr_i  = instr;
        id_base_i   = base;
        id_offset_i = off;
        id_rs1_i    = rs1;
        id_rs2_i    = rs2;
        id_rd_i     = rd;
        id_xid_i    = xid;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = 32'h0;
        rf[1] = 32'h0003_0002;
        rf[2] = 32'hFFFF_0004;
        rf[3] = 32'd10;
        rf[4] = 32'hCAFE_F00D;
        rf[7] = 32'd100;
        rst_i = 1'b1;
        id_valid_i = 1'b0; id_instr_i = 2'd0; id_base_i = '0; id_offset_i = '0;
        id_rs1_i = '0; id_rs2_i = '0; id_rd_i = '0; id_xid_i = '0;
        mem_ready_i = 1'b0; mem_result_valid_i = 1'b0; mem_result_rdata_i = '0; mem_result_err_i = 1'b0;

        // Reset state
        tick(); tick();
        check("rst_id_ready",  32'(id_ready_o),  32'd1);
        check("rst_mem_valid", 32'(mem_valid_o), 32'd0);
        check("rst_wb_valid",  32'(wb_valid_o),  32'd0);
        check("rst_err",       32'(err_o),       32'd0);
        check("rst_mem_addr",  mem_addr_o,       32'd0);
        check("rst_mem_be",    32'(mem_be_o),    32'd0);
        rst_i = 1'b0;
        tick();

        // DOTP: 10 + 2*4 + 3*(-1) = 15
        issue(2'd3, 32'h0, 12'h0, 5'd1, 5'd2, 5'd3, 4'h7);
        tick();
        id_valid_i = 1'b0;
        check("dotp_wb_valid", 32'(wb_valid_o), 32'd1);
        check("dotp_wb_data",  wb_data_o,       32'd15);
        check("dotp_wb_rd",    32'(wb_rd_o),    32'd3);
        check("dotp_wb_xid",   32'(wb_xid_o),   32'h7);
        check("dotp_no_mem",   32'(mem_valid_o), 32'd0);
        check("dotp_id_ready", 32'(id_ready_o),  32'd1);
        tick();
        check("dotp_wb_pulse", 32'(wb_valid_o), 32'd0);

        // INVALID: consumed, nothing happens
        issue(2'd0, 32'h0, 12'h0, 5'd1, 5'd2, 5'd3, 4'h1);
        tick();
        id_valid_i = 1'b0;
        check("inv_wb_valid",  32'(wb_valid_o),  32'd0);
        check("inv_err",       32'(err_o),       32'd0);
        check("inv_mem_valid", 32'(mem_valid_o), 32'd0);
        check("inv_id_ready",  32'(id_ready_o),  32'd1);

        // LW 0x1000 + (-4) = 0x0FFC with a 3-cycle stall; a stray result in
        // MEM_REQ must be ignored.
        issue(2'd1, 32'h1000, 12'hFFC, 5'd0, 5'd0, 5'd6, 4'h2);
        tick();
        id_valid_i = 1'b0;
        check("lw_mem_valid", 32'(mem_valid_o), 32'd1);
        check("lw_mem_addr",  mem_addr_o,       32'h0000_0FFC);
        check("lw_mem_we",    32'(mem_we_o),    32'd0);
        check("lw_mem_be",    32'(mem_be_o),    32'hF);
        check("lw_mem_xid",   32'(mem_xid_o),   32'h2);
        check("lw_id_ready",  32'(id_ready_o),  32'd0);
        for (int i = 0; i < 3; i++) begin
            mem_result_valid_i = (i == 0);
            mem_result_rdata_i = 32'h1234_5678;
            id_base_i = 32'h7777_0000 + 32'(i);
            tick();
            check("lw_stall_valid", 32'(mem_valid_o), 32'd1);
            check("lw_stall_addr",  mem_addr_o,       32'h0000_0FFC);
            check("lw_stall_nowb",  32'(wb_valid_o),  32'd0);
        end
        mem_result_valid_i = 1'b0;
        mem_ready_i = 1'b1;
        tick();
        mem_ready_i = 1'b0;
        check("lw_hs_valid_drop", 32'(mem_valid_o), 32'd0);
        check("lw_wait_busy",     32'(id_ready_o),  32'd0);
        tick();
        check("lw_wait_still", 32'(id_ready_o), 32'd0);
        mem_result_valid_i = 1'b1;
        mem_result_rdata_i = 32'hDEAD_BEEF;
        tick();
        mem_result_valid_i = 1'b0;
        check("lw_wb_valid", 32'(wb_valid_o), 32'd1);
        check("lw_wb_data",  wb_data_o,       32'hDEAD_BEEF);
        check("lw_wb_rd",    32'(wb_rd_o),    32'd6);
        check("lw_wb_xid",   32'(wb_xid_o),   32'h2);
        check("lw_id_ready", 32'(id_ready_o), 32'd1);
        tick();

        // Misaligned SW: dropped with an error pulse
        issue(2'd2, 32'h2002, 12'h000, 5'd0, 5'd4, 5'd0, 4'h3);
        tick();
        id_valid_i = 1'b0;
        check("mis_err",       32'(err_o),       32'd1);
        check("mis_mem_valid", 32'(mem_valid_o), 32'd0);
        check("mis_id_ready",  32'(id_ready_o),  32'd1);
        check("mis_wb_valid",  32'(wb_valid_o),  32'd0);
        tick();
        check("mis_err_pulse", 32'(err_o), 32'd0);

        // Aligned SW: store data from rs2, no writeback
        mem_ready_i = 1'b1;
        issue(2'd2, 32'h3000, 12'h010, 5'd0, 5'd4, 5'd9, 4'h5);
        tick();
        id_valid_i = 1'b0;
        check("sw_mem_valid", 32'(mem_valid_o), 32'd1);
        check("sw_mem_we",    32'(mem_we_o),    32'd1);
        check("sw_mem_addr",  mem_addr_o,       32'h0000_3010);
        check("sw_mem_wdata", mem_wdata_o,      32'hCAFE_F00D);
        tick();
        check("sw_hs_drop", 32'(mem_valid_o), 32'd0);
        mem_result_valid_i = 1'b1;
        mem_result_rdata_i = 32'hAAAA_AAAA;
        tick();
        mem_result_valid_i = 1'b0;
        check("sw_no_wb",    32'(wb_valid_o), 32'd0);
        check("sw_no_err",   32'(err_o),      32'd0);
        check("sw_id_ready", 32'(id_ready_o), 32'd1);

        // LW to r5 then back-to-back DOTP reading r5: 100 + 3*4 + 2*(-1) = 110
        issue(2'd1, 32'h0000_0100, 12'h000, 5'd0, 5'd0, 5'd5, 4'h4);
        tick();
        id_valid_i = 1'b0;
        tick();
        mem_result_valid_i = 1'b1;
        mem_result_rdata_i = 32'h0002_0003;
        tick();
        mem_result_valid_i = 1'b0;
        check("fwd_lw_wb_data", wb_data_o, 32'h0002_0003);
        issue(2'd3, 32'h0, 12'h0, 5'd5, 5'd2, 5'd7, 4'h6);
        check("fwd_id_ready", 32'(id_ready_o), 32'd1);
        tick();
        id_valid_i = 1'b0;
        check("fwd_dotp_valid", 32'(wb_valid_o), 32'd1);
        check("fwd_dotp_data",  wb_data_o,       32'd110);
        check("fwd_dotp_rd",    32'(wb_rd_o),    32'd7);

        // LW with memory error: error pulse, no writeback
        issue(2'd1, 32'h0000_0040, 12'h000, 5'd0, 5'd0, 5'd9, 4'h8);
        tick();
        id_valid_i = 1'b0;
        tick();
        mem_result_valid_i = 1'b1;
        mem_result_err_i = 1'b1;
        tick();
        mem_result_valid_i = 1'b0;
        mem_result_err_i = 1'b0;
        check("merr_err",   32'(err_o),      32'd1);
        check("merr_no_wb", 32'(wb_valid_o), 32'd0);
        mem_ready_i = 1'b0;

        // Negative offset wraps: 0 + (-2048) = 0xFFFFF800; reset in MEM_WAIT
        issue(2'd1, 32'h0, 12'h800, 5'd0, 5'd0, 5'd10, 4'h9);
        tick();
        id_valid_i = 1'b0;
        check("wrap_addr", mem_addr_o, 32'hFFFF_F800);
        mem_ready_i = 1'b1;
        tick();
        mem_ready_i = 1'b0;
        check("rstw_in_wait", 32'(id_ready_o), 32'd0);
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        check("rstw_id_ready", 32'(id_ready_o),  32'd1);
        check("rstw_mem_addr", mem_addr_o,       32'd0);
        check("rstw_mem_valid", 32'(mem_valid_o), 32'd0);
        mem_result_valid_i = 1'b1;
        mem_result_rdata_i = 32'h0000_0055;
        tick();
        mem_result_valid_i = 1'b0;
        check("rstw_no_wb",  32'(wb_valid_o), 32'd0);
        check("rstw_no_err", 32'(err_o),      32'd0);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fir_xifu_ex.md
FIR_XIFU_EX -- requirements
Module: fir_xifu_ex

Interface
REQ-001 Parameter X_ID_WIDTH, default 4, SHALL set the width of the XIF instruction-ID field.
REQ-002 clk_i  in  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst_i  in  1  reset, synchronous and active-high.
REQ-004 id_valid_i  in  1  ID/EX register holds a valid instruction.
REQ-005 id_ready_o  out  1  EX accepts the ID/EX register this cycle.
REQ-006 id_instr_i  in  2  0 INVALID, 1 XFIRLW, 2 XFIRSW, 3 XFIRDOTP.
REQ-007 id_base_i  in  32  rs1 value from the core.
REQ-008 id_offset_i  in  12  I/S immediate, two's complement.
REQ-009 id_rs1_i, id_rs2_i, id_rd_i  in  5 each  XIFU register indices.
REQ-010 id_xid_i  in  X_ID_WIDTH  XIF instruction ID.
REQ-011 rf_raddr_a_o, rf_raddr_b_o, rf_raddr_c_o  out  5 each  XIFU regfile read addresses; rf_rdata_a_i, rf_rdata_b_i, rf_rdata_c_i  in  32 each  combinational read data.
REQ-012 mem_valid_o, mem_ready_i  out/in  1  XIF memory request handshake.
REQ-013 mem_addr_o 32, mem_we_o 1, mem_be_o 4, mem_wdata_o 32, mem_xid_o X_ID_WIDTH  out  request payload.
REQ-014 mem_result_valid_i 1, mem_result_rdata_i 32, mem_result_err_i 1  in  memory result.
REQ-015 wb_valid_o 1, wb_rd_o 5, wb_data_o 32, wb_xid_o X_ID_WIDTH  out  registered XIFU regfile write port.
REQ-016 err_o  out  1  one-cycle pulse on a dropped instruction.

Function
REQ-017 FSM states SHALL be IDLE, MEM_REQ, MEM_WAIT; id_ready_o SHALL be 1 only in IDLE.
REQ-018 Accept SHALL occur when id_valid_i & id_ready_o; INVALID accepted and discarded, no side effects.
REQ-019 Address SHALL be id_base_i + sign-extended id_offset_i, modulo 2^32, latched at accept.
REQ-020 Read ports SHALL be driven a=id_rs1_i, b=id_rs2_i, c=id_rd_i in IDLE.
REQ-021 Forwarding: if wb_valid_o=1 and wb_rd_o equals a read address, the operand SHALL be wb_data_o, not rf_rdata.
REQ-022 XFIRDOTP SHALL complete at accept: wb_valid_o=1 next cycle, wb_data_o = c + sext(a[15:0])*sext(b[15:0]) + sext(a[31:16])*sext(b[31:16]), 32-bit wrap, FSM stays IDLE.
REQ-023 XFIRLW/XFIRSW with address[1:0]!=0 SHALL not issue; err_o=1 next cycle; FSM stays IDLE.
REQ-024 Aligned XFIRLW/XFIRSW SHALL go to MEM_REQ; mem_valid_o=1, mem_be_o=4'hF, mem_we_o=1 for SW, 0 for LW, mem_wdata_o = operand b latched at accept (forwarded per REQ-021).
REQ-025 Payload SHALL be stable while mem_valid_o=1 and mem_ready_i=0; mem_valid_o SHALL not drop before the handshake.
REQ-026 On mem_valid_o & mem_ready_i: go to MEM_WAIT, mem_valid_o=0 next cycle.
REQ-027 In MEM_WAIT on mem_result_valid_i: go to IDLE; if err, err_o=1 next cycle, no writeback; else LW SHALL produce wb_valid_o=1, wb_data_o=mem_result_rdata_i next cycle; SW no writeback.
REQ-028 mem_result_valid_i outside MEM_WAIT SHALL be ignored.
REQ-029 wb_valid_o and err_o SHALL be single-cycle pulses; wb_rd_o/wb_xid_o carry the accepted rd/xid.
REQ-030 Minimum latency: DOTP 1 cycle; LW with mem_ready_i=1 and result next cycle, accept to wb_valid_o = 3 cycles.

Reset
REQ-031 With rst_i=1 at a clock edge: FSM to IDLE; mem_valid_o, wb_valid_o, err_o, latched payload to 0; id_ready_o=1 the following cycle.
REQ-032 Reset in MEM_REQ/MEM_WAIT SHALL abandon the operation; a later mem_result_valid_i SHALL be ignored.

Verification
REQ-033 DOTP a=0x0003_0002, b=0xFFFF_0004, c=10 -> wb_data_o=15 one cycle after accept.
REQ-034 LW base=0x1000, offset=0xFFC, mem_ready_i low 3 cycles -> mem_addr_o=0x0FFC held stable, result 0xDEADBEEF -> wb_data_o=0xDEADBEEF.
REQ-035 SW base=0x2002, offset=0 -> no mem_valid_o, err_o pulse, id_ready_o stays 1.
REQ-036 LW to rd=5 then DOTP with rs1=5 back-to-back -> DOTP uses forwarded load data.
REQ-037 rst_i asserted in MEM_WAIT, then mem_result_valid_i -> no wb_valid_o, no err_o.
